// File: rtl/cic_pkg.sv
// Shared CIC filter constants and helpers.
// Used by the decimator and the interpolator.
package cic_pkg;

  localparam int CIC_N        = 4;
  localparam int CIC_RATE_LOG = 7;
  localparam int CIC_RW       = 8;

  // Internal register width after worst-case bit growth
  function automatic int cic_iw(input int w);
    return w + CIC_N * CIC_RATE_LOG;
  endfunction

  // Smallest k with 2**k >= v, for v in 1..255
  function automatic logic [3:0] ceil_log2(
    input logic [CIC_RW-1:0] v
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < CIC_RW; i++) begin
      if ((9'd1 << i) < {1'b0, v}) begin
        r = 4'(i + 1);
      end
    end
    return r;
  endfunction

  // A rate of zero behaves as a rate of one
  function automatic logic [CIC_RW-1:0] rate_eff(
    input logic [CIC_RW-1:0] r
  );
    return (r == '0) ? CIC_RW'(1) : r;
  endfunction

endpackage

// File: rtl/cic_decim_gain.sv
// CIC decimator output stage: gain shift
// selection and registered data/strobe.
module cic_decim_gain
  import cic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    dec,
  input  logic [CIC_RW-1:0]       r_act,
  input  logic [cic_iw(WIDTH)-1:0] comb_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    stb_out
);

  logic [5:0]       shift_q;
  logic [5:0]       shift_d;
  logic             vld_q;
  logic             vld_d;
  logic             stb_q;
  logic             stb_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Latch the frame's shift at dec, slice the
  // final comb output one cycle later.
  always_comb begin
    shift_d = shift_q;
    if (dec) begin
      shift_d = 6'(CIC_N * int'(ceil_log2(r_act)));
    end
    vld_d  = dec;
    stb_d  = vld_q;
    data_d = data_q;
    if (vld_q) begin
      data_d = WIDTH'(comb_in >> shift_q);
    end
  end

  // Output registers, cleared with the filter
  always_ff @(posedge clk) begin
    if (clr) begin
      shift_q <= '0;
      vld_q   <= 1'b0;
      stb_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      shift_q <= shift_d;
      vld_q   <= vld_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
    end
  end

  assign data_out = data_q;
  assign stb_out  = stb_q;

endmodule

// File: rtl/cic_decimator.sv
// Four-stage CIC decimator with runtime rate
// 1..128, pipelined integrators and combs.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [7:0]        rate,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              stb_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              stb_out
);

  localparam int IW = cic_iw(WIDTH);
  localparam int NS = CIC_N;

  logic                    clr;
  logic                    acc;
  logic                    dec;
  logic [CIC_RW-1:0]       r_new;
  logic [IW-1:0]           ext_in;
  logic [IW-1:0]           comb_last;

  logic [IW-1:0]           int_q  [NS];
  logic [IW-1:0]           int_d  [NS];
  logic [IW-1:0]           comb_q [NS-1];
  logic [IW-1:0]           comb_d [NS-1];
  logic [IW-1:0]           dly_q  [NS];
  logic [IW-1:0]           dly_d  [NS];

  logic [CIC_RATE_LOG-1:0] cnt_q;
  logic [CIC_RATE_LOG-1:0] cnt_d;
  logic [CIC_RW-1:0]       r_act_q;
  logic [CIC_RW-1:0]       r_act_d;
  logic                    dec_q;
  logic                    dec_d;

  assign clr = rst | ~enable;

  // Accept strobe, detect end of frame
  always_comb begin
    ext_in = {{(IW-WIDTH){data_in[WIDTH-1]}}, data_in};
    acc    = stb_in & ~clr;
    dec    = acc & ({1'b0, cnt_q} == (r_act_q - 8'd1));
    r_new  = rate_eff(rate);
  end

  // Integrator chain, each stage fed by the
  // previous stage's old value
  always_comb begin
    int_d = int_q;
    if (acc) begin
      int_d[0] = int_q[0] + ext_in;
      for (int i = 1; i < NS; i++) begin
        int_d[i] = int_q[i] + int_q[i-1];
      end
    end
  end

  // Sample counter; rate only reloads at a
  // frame boundary so changes wait a frame
  always_comb begin
    cnt_d   = cnt_q;
    r_act_d = r_act_q;
    dec_d   = dec;
    if (acc) begin
      cnt_d = dec ? '0 : cnt_q + 7'd1;
    end
    if (dec) begin
      r_act_d = r_new;
    end
  end

  // Comb chain, one stage per output sample;
  // the last stage goes straight to the slicer
  always_comb begin
    comb_d    = comb_q;
    dly_d     = dly_q;
    comb_last = comb_q[NS-2] - dly_q[NS-1];
    if (dec_q) begin
      comb_d[0] = int_q[NS-1] - dly_q[0];
      dly_d[0]  = int_q[NS-1];
      for (int i = 1; i < NS-1; i++) begin
        comb_d[i] = comb_q[i-1] - dly_q[i];
        dly_d[i]  = comb_q[i-1];
      end
      dly_d[NS-1] = comb_q[NS-2];
    end
  end

  // Filter state; clear also reloads the rate
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NS; i++) begin
        int_q[i] <= '0;
        dly_q[i] <= '0;
      end
      for (int i = 0; i < NS-1; i++) begin
        comb_q[i] <= '0;
      end
      cnt_q   <= '0;
      r_act_q <= r_new;
      dec_q   <= 1'b0;
    end else begin
      int_q   <= int_d;
      dly_q   <= dly_d;
      comb_q  <= comb_d;
      cnt_q   <= cnt_d;
      r_act_q <= r_act_d;
      dec_q   <= dec_d;
    end
  end

  cic_decim_gain #(
    .WIDTH (WIDTH)
  ) u_gain (
    .clk      (clk),
    .clr      (clr),
    .dec      (dec),
    .r_act    (r_act_q),
    .comb_in  (comb_last),
    .data_out (data_out),
    .stb_out  (stb_out)
  );

endmodule
